// File: rtl/bexkat1_pkg.sv
// Shared bexkat1 definitions: default responder geometry and the in-flight
// pipeline entry carried from request acceptance to acknowledge.
package bexkat1_pkg;

  localparam int DEF_AWIDTH  = 10;
  localparam int DEF_LATENCY = 2;
  localparam int DEF_MAXOUT  = 4;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] data;
  } pipe_entry_t;

endpackage

// File: rtl/syncram_be.sv
// Single-port synchronous RAM with per-byte write enables; contents are
// deliberately not reset so data survives a bus reset.
module syncram_be #(
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [3:0]        sel,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**AWIDTH];

  // Read data only moves on an enabled read so the last word stays stable.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (sel[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/bus_responder.sv
// Pipelined Wishbone memory responder: fixed-latency in-order acks, bounded
// outstanding requests, and cyc_i-based abort of everything in flight.
module bus_responder
  import bexkat1_pkg::*;
#(
  parameter int AWIDTH  = DEF_AWIDTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int MAXOUT  = DEF_MAXOUT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        stall_o
);

  localparam int CW = $clog2(MAXOUT + 1);

  logic [CW-1:0] out_cnt;
  logic          accept;
  logic          read_ack;
  logic [31:0]   rd_data;
  logic [31:0]   dat_hold;
  pipe_entry_t   pipe [LATENCY];
  pipe_entry_t   tail;
  logic          unused_adr;

  assign unused_adr = ^{adr_i[31:AWIDTH+2], adr_i[1:0]};

  assign stall_o = (out_cnt == CW'(MAXOUT));
  assign accept  = cyc_i & stb_i & ~stall_o;

  syncram_be #(.AWIDTH(AWIDTH)) u_ram (
    .clk   (clk_i),
    .en    (accept),
    .we    (we_i),
    .addr  (adr_i[AWIDTH+1:2]),
    .sel   (sel_i),
    .wdata (dat_i),
    .rdata (rd_data)
  );

  // Stage 0 tracks the RAM read cycle; its data lives in the RAM output
  // register, so the word is picked up when moving into stage 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else if (!cyc_i) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: accept, we: we_i, data: 32'h0};
      for (int i = 1; i < LATENCY; i++) begin
        if (i == 1) pipe[i] <= '{valid: pipe[0].valid, we: pipe[0].we, data: rd_data};
        else        pipe[i] <= pipe[i-1];
      end
    end
  end

  always_comb begin
    tail = pipe[LATENCY-1];
    if (LATENCY == 1) tail.data = rd_data;
  end

  assign ack_o    = tail.valid & cyc_i;
  assign read_ack = ack_o & ~tail.we;
  assign dat_o    = read_ack ? tail.data : dat_hold;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dat_hold <= 32'h0;
    end else if (read_ack) begin
      dat_hold <= tail.data;
    end
  end

  // Accept and ack in the same cycle cancel out; dropping cyc_i forgets all.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_cnt <= '0;
    end else if (!cyc_i) begin
      out_cnt <= '0;
    end else if (accept && !ack_o) begin
      out_cnt <= out_cnt + CW'(1);
    end else if (ack_o && !accept) begin
      out_cnt <= out_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Drives two responder configurations with identical bus traffic and checks
// each against a queue-based model of the bus rules.
module tb_bus_responder;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic [31:0] dat_o_w [2];
  logic        ack_w   [2];
  logic        stall_w [2];

  bus_responder #(.AWIDTH(10), .LATENCY(2), .MAXOUT(4)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .adr_i(adr), .sel_i(sel), .dat_i(dat),
    .dat_o(dat_o_w[0]), .ack_o(ack_w[0]), .stall_o(stall_w[0])
  );

  bus_responder #(.AWIDTH(10), .LATENCY(4), .MAXOUT(2)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .adr_i(adr), .sel_i(sel), .dat_i(dat),
    .dat_o(dat_o_w[1]), .ack_o(ack_w[1]), .stall_o(stall_w[1])
  );

  always #5 clk = ~clk;

  function automatic int lat_of(int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic int max_of(int i);
    return (i == 0) ? 4 : 2;
  endfunction

  // Model: per instance a FIFO of accepted requests with their age in cycles,
  // plus a memory image and the last read data returned.
  int          head   [2];
  int          tail   [2];
  int          age_q  [2][16];
  bit          we_q   [2][16];
  logic [31:0] data_q [2][16];
  logic [31:0] mm     [2][1024];
  logic [31:0] hold   [2];
  int          checks = 0;
  int          errors = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      head[i] = tail[i];
      hold[i] = 32'h0;
    end
  endtask

  task automatic model_edge(int i, bit ea, bit acc);
    int idx;
    int slot;
    if (ea) begin
      if (!we_q[i][head[i] % 16]) hold[i] = data_q[i][head[i] % 16];
      head[i]++;
    end
    for (int k = head[i]; k < tail[i]; k++) age_q[i][k % 16]++;
    if (!cyc) begin
      head[i] = tail[i];
    end else if (acc) begin
      idx  = int'(adr[11:2]);
      slot = tail[i] % 16;
      we_q[i][slot]  = we;
      age_q[i][slot] = 0;
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (sel[b]) mm[i][idx][8*b +: 8] = dat[8*b +: 8];
        end
        data_q[i][slot] = 32'h0;
      end else begin
        data_q[i][slot] = mm[i][idx];
      end
      tail[i]++;
    end
  endtask

  // One bus cycle: check outputs mid-cycle, then advance the model on the edge.
  task automatic cycle();
    bit ea  [2];
    bit acc [2];
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      int          h;
      logic [31:0] ed;
      bit          es;
      h     = head[i] % 16;
      ea[i] = cyc && (tail[i] > head[i]) && (age_q[i][h] == lat_of(i) - 1);
      ed    = (ea[i] && !we_q[i][h]) ? data_q[i][h] : hold[i];
      es    = ((tail[i] - head[i]) == max_of(i));
      check($sformatf("ack[%0d]", i), {31'b0, ack_w[i]}, {31'b0, ea[i]});
      check($sformatf("stall[%0d]", i), {31'b0, stall_w[i]}, {31'b0, es});
      check($sformatf("dat_o[%0d]", i), dat_o_w[i], ed);
      acc[i] = cyc && stb && !es;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i, ea[i], acc[i]);
    #1;
  endtask

  task automatic drive(bit c, bit s, bit w, logic [31:0] a, logic [3:0] sl, logic [31:0] d);
    cyc = c; stb = s; we = w; adr = a; sel = sl; dat = d;
    cycle();
  endtask

  task automatic req(bit w, logic [31:0] a, logic [3:0] sl, logic [31:0] d);
    drive(1'b1, 1'b1, w, a, sl, d);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  // Read on both instances; the LATENCY=2 instance acks one cycle later.
  task automatic rd0(string tag, logic [31:0] a, logic [31:0] exp);
    req(1'b0, a, 4'h0, 32'h0);
    idle(1);
    check({tag, "_ack"}, {31'b0, ack_w[0]}, 32'h1);
    check({tag, "_dat"}, dat_o_w[0], exp);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not end, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 2; i++) begin
      head[i] = 0; tail[i] = 0; hold[i] = 32'h0;
    end
    rst_i = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = 32'h0; sel = 4'h0; dat = 32'h0;

    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_ack[%0d]", i), {31'b0, ack_w[i]}, 32'h0);
      check($sformatf("rst_stall[%0d]", i), {31'b0, stall_w[i]}, 32'h0);
      check($sformatf("rst_dat[%0d]", i), dat_o_w[i], 32'h0);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Preload the first 16 words, draining so the MAXOUT=2 instance keeps up.
    for (int w = 0; w < 16; w++) begin
      req(1'b1, w << 2, 4'hF, $urandom());
      idle(4);
    end

    req(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
    idle(1);
    check("wr_ack", {31'b0, ack_w[0]}, 32'h1);
    idle(4);
    rd0("raw_full", 32'h0000_0010, 32'hDEAD_BEEF);
    idle(5);

    req(1'b1, 32'h0000_0020, 4'hF, 32'h0000_0000);
    req(1'b1, 32'h0000_0020, 4'h5, 32'h1122_3344);
    rd0("lanes", 32'h0000_0020, 32'h0022_0044);
    idle(5);

    v = $urandom();
    req(1'b1, 32'h0000_1004, 4'hF, v);
    idle(4);
    rd0("alias", 32'h0000_0004, v);
    idle(5);

    req(1'b0, 32'h0000_0000, 4'h0, 32'h0);
    req(1'b0, 32'h0000_0004, 4'h0, 32'h0);
    check("stall_full[1]", {31'b0, stall_w[1]}, 32'h1);
    check("stall_free[0]", {31'b0, stall_w[0]}, 32'h0);
    for (int k = 2; k < 5; k++) req(1'b0, k << 2, 4'h0, 32'h0);
    idle(6);

    req(1'b0, 32'h0000_0008, 4'h0, 32'h0);
    req(1'b0, 32'h0000_000C, 4'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("abort_stall[0]", {31'b0, stall_w[0]}, 32'h0);
    check("abort_stall[1]", {31'b0, stall_w[1]}, 32'h0);
    idle(5);
    rd0("post_abort", 32'h0000_0010, 32'hDEAD_BEEF);
    idle(5);

    for (int k = 0; k < 3; k++) req(1'b0, (k + 5) << 2, 4'h0, 32'h0);
    stb = 1'b0;
    rst_i = 1'b1;
    #1;
    check("midrst_ack[0]", {31'b0, ack_w[0]}, 32'h0);
    check("midrst_dat[0]", dat_o_w[0], 32'h0);
    check("midrst_ack[1]", {31'b0, ack_w[1]}, 32'h0);
    check("midrst_dat[1]", dat_o_w[1], 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst_i = 1'b0;
    rd0("after_rst", 32'h0000_0010, 32'hDEAD_BEEF);
    idle(5);

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2),
            4'($urandom()), $urandom());
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter AWIDTH, default 10, word-address bits of the internal memory (2**AWIDTH 32-bit words).
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to ack; legal range 1..4.
REQ-003 Parameter MAXOUT, default 4, maximum accepted-but-unacked requests; legal range 1..8.
REQ-004 clk_i  input  1  sole clock; all state on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 cyc_i  input  1  Wishbone cycle valid from initiator.
REQ-007 stb_i  input  1  request strobe (pipelined Wishbone).
REQ-008 we_i  input  1  1 = write, 0 = read.
REQ-009 adr_i  input  32  byte address; word index = adr_i[AWIDTH+1:2]; other bits ignored.
REQ-010 sel_i  input  4  byte-lane enables for writes; sel_i[0] = bits 7:0.
REQ-011 dat_i  input  32  write data.
REQ-012 dat_o  output  32  read data, valid when ack_o=1 for a read.
REQ-013 ack_o  output  1  one-cycle completion strobe per accepted request.
REQ-014 stall_o  output  1  request not accepted this cycle.

Function
REQ-015 Accept = cyc_i & stb_i & ~stall_o; exactly one request accepted per accept cycle.
REQ-016 stall_o SHALL be 1 when outstanding count == MAXOUT, else 0; it is independent of stb_i.
REQ-017 Outstanding count: +1 on accept, -1 on ack_o, unchanged when both occur in the same cycle; never exceeds MAXOUT.
REQ-018 Each accepted request SHALL produce ack_o exactly LATENCY cycles after its accept edge; acks are in acceptance order, one per cycle max.
REQ-019 Back-to-back accepts SHALL give back-to-back acks (full throughput when MAXOUT >= LATENCY).
REQ-020 Writes commit to memory on the accept edge, only the lanes with sel_i bit set; unselected lanes keep their value.
REQ-021 Reads return the memory word as of the accept edge, including any write accepted on an earlier cycle (read-after-write ordering preserved).
REQ-022 Read data SHALL pass a LATENCY-stage valid/data pipeline: one synchronous RAM read stage plus LATENCY-1 registers.
REQ-023 dat_o SHALL update only on a read ack and hold its value otherwise; a write ack leaves dat_o unchanged.
REQ-024 ack_o SHALL be gated by cyc_i: no ack while cyc_i=0.
REQ-025 cyc_i falling (abort): all in-flight valid bits and the outstanding count clear on the next edge; aborted reads never ack; writes already accepted remain committed.
REQ-026 stb_i with cyc_i=0 SHALL be ignored (no accept, no memory change).
REQ-027 Address aliasing: addresses differing only above bit AWIDTH+1 SHALL hit the same word.

Reset
REQ-028 On rst_i=1 asynchronously: ack_o=0, stall_o=0, dat_o=32'h0, outstanding count=0, all pipeline valid bits=0.
REQ-029 Reset mid-transfer SHALL drop all in-flight requests without ack; memory contents are not reset.
REQ-030 First accept is possible on the first rising edge after rst_i deasserts.

Structure
REQ-031 Default AWIDTH/LATENCY/MAXOUT constants and the in-flight pipeline entry typedef (valid, we, 32-bit data) SHALL live in the shared bexkat1 package.
REQ-032 One sub-module, syncram_be, SHALL hold the byte-enabled single-port synchronous RAM; control, counter and pipeline stay in bus_responder.

Verification
REQ-033 Write adr 0x10 dat 0xDEADBEEF sel 0xF, then read adr 0x10 -> write ack at +2, read ack at +2 with dat_o=0xDEADBEEF.
REQ-034 Write 0x00000000 sel 0xF then 0x11223344 sel 0x5 to adr 0x20, read -> dat_o=0x00220044.
REQ-035 Five back-to-back reads, LATENCY=2, MAXOUT=4 -> no stall, five consecutive ack cycles in order; with LATENCY=4, MAXOUT=2 -> stall_o=1 after 2 accepts, releases the cycle an ack occurs.
REQ-036 Two reads accepted, cyc_i dropped next cycle -> no ack_o, count=0, stall_o=0; a subsequent read acks normally.
REQ-037 rst_i pulsed mid-burst with 3 outstanding -> ack_o=0, dat_o=0 immediately; earlier-written word still readable after reset.
REQ-038 Write adr 0x00001004, read adr 0x00000004 (AWIDTH=10) -> same data returned.
